// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: state encoding for the sequential adders.
package arith_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the single arithmetic cell reused by the bit-serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout, sum} = a + b + cin, one bit per cycle LSB-first through a
// single full_adder, with valid/ready handshakes on both the operand and result sides.
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q,  carry_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             fa_s;
  logic             fa_cout;

  full_adder u_full_adder (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a signal
    // unassigned; that is what keeps this block free of inferred latches.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          sum_sh_d = '0;
          carry_d  = cin;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // The new sum bit enters at the MSB so after WIDTH shifts bit 0 is the LSB result.
        sum_sh_d = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1] = fa_s;
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  // Handshake flags and result come only from flops, never from in_valid/out_ready.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = out_valid ? sum_sh_q : '0;
  assign cout      = out_valid & carry_q;

endmodule
